bus_hold_arbiter: RTL and testbench

//  N-requester bus-hold arbiter for the XT system bus; generalises the single DMA/ext hold path.

---
 rtl/bus_hold_arbiter_if.sv | 27 ++
 rtl/bus_hold_arbiter.sv | 153 +++++++++++++++
 tb/tb_bus_hold_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_hold_arbiter_if.sv
// Bus-side signal bundle for the XT bus-hold arbiter: CPU status inputs, master requests, grants and bus controls.
interface bus_hold_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
);
    logic                   cpu_clock;
    logic [2:0]             processor_status;
    logic                   processor_lock_n;
    logic                   rotate_priority;
    logic [NUM_MASTERS-1:0] request;
    logic [NUM_MASTERS-1:0] grant;
    logic [IDX_W-1:0]       grant_index;
    logic                   hold_acknowledge;
    logic                   address_enable_n;
    logic                   bus_wait_n;
    logic                   tenure_expired;

    modport master (
        output cpu_clock, processor_status, processor_lock_n, rotate_priority, request,
        input  grant, grant_index, hold_acknowledge, address_enable_n, bus_wait_n, tenure_expired
    );

    modport slave (
        input  cpu_clock, processor_status, processor_lock_n, rotate_priority, request,
        output grant, grant_index, hold_acknowledge, address_enable_n, bus_wait_n, tenure_expired
    );
endinterface

// File: rtl/bus_hold_arbiter.sv
// N-requester bus-hold arbiter: takes the XT bus from the 8088 in its passive state and
// grants it to one DMA/expansion master under fixed or rotating priority with an optional tenure limit.
module bus_hold_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int MAX_TENURE  = 0,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic               clock,
    input  logic               reset,
    bus_hold_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        SAMPLED,
        HOLD,
        FLOAT,
        OWNED,
        RELEASE
    } state_t;

    localparam int                TEN_W    = (MAX_TENURE > 0) ? $clog2(MAX_TENURE + 1) : 1;
    localparam logic [TEN_W-1:0]  TEN_LAST = TEN_W'((MAX_TENURE > 0) ? MAX_TENURE - 1 : 0);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_MASTERS - 1);

    state_t           state;
    logic             prev_cpu_clock;
    logic [IDX_W-1:0] last_grant;
    logic [TEN_W-1:0] tenure;

    logic             cpu_pos;
    logic             cpu_neg;
    logic             any_req;
    logic             passive;
    logic             timeout;
    logic             owner_req;
    logic [IDX_W:0]   winner;
    logic             unused_status;

    // Returns {found, index}; rotating scan starts just past the previous owner.
    function automatic logic [IDX_W:0] pick_winner(
        input logic [NUM_MASTERS-1:0] req,
        input logic                   rotate,
        input logic [IDX_W-1:0]       last
    );
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = rotate ? IDX_W'((int'(last) + 1 + i) % NUM_MASTERS) : IDX_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [TEN_W-1:0] tenure_inc(input logic [TEN_W-1:0] t);
        return (&t) ? t : t + 1'b1;
    endfunction

    assign cpu_pos       = ~prev_cpu_clock & bus.cpu_clock;
    assign cpu_neg       = prev_cpu_clock & ~bus.cpu_clock;
    assign any_req       = |bus.request;
    assign passive       = (bus.processor_status[1:0] == 2'b11);
    assign unused_status = bus.processor_status[2];
    assign timeout       = (MAX_TENURE > 0) && (tenure == TEN_LAST);
    assign owner_req     = bus.request[bus.grant_index];
    assign winner        = pick_winner(bus.request, bus.rotate_priority, last_grant);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            prev_cpu_clock       <= 1'b0;
            last_grant           <= LAST_IDX;
            tenure               <= '0;
            bus.grant            <= '0;
            bus.grant_index      <= '0;
            bus.hold_acknowledge <= 1'b0;
            bus.address_enable_n <= 1'b0;
            bus.bus_wait_n       <= 1'b1;
            bus.tenure_expired   <= 1'b0;
        end else begin
            prev_cpu_clock     <= bus.cpu_clock;
            bus.tenure_expired <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_pos && any_req && passive && bus.processor_lock_n)
                        state <= SAMPLED;
                end
                SAMPLED: begin
                    if (cpu_neg) begin
                        if (any_req) begin
                            state                <= HOLD;
                            bus.hold_acknowledge <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (cpu_pos) begin
                        if (any_req) begin
                            state                <= FLOAT;
                            bus.address_enable_n <= 1'b1;
                        end else begin
                            state                <= IDLE;
                            bus.hold_acknowledge <= 1'b0;
                        end
                    end
                end
                FLOAT: begin
                    if (cpu_pos) begin
                        if (winner[IDX_W]) begin
                            state           <= OWNED;
                            bus.grant       <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << winner[IDX_W-1:0];
                            bus.grant_index <= winner[IDX_W-1:0];
                            bus.bus_wait_n  <= 1'b0;
                            tenure          <= '0;
                        end else begin
                            state <= RELEASE;
                        end
                    end
                end
                OWNED: begin
                    // Only the owner's own request or the tenure limit ends ownership.
                    if (cpu_pos) begin
                        tenure <= tenure_inc(tenure);
                        if (!owner_req || timeout) begin
                            state              <= RELEASE;
                            bus.grant          <= '0;
                            last_grant         <= bus.grant_index;
                            bus.tenure_expired <= timeout && owner_req;
                        end
                    end
                end
                RELEASE: begin
                    if (cpu_pos) begin
                        state                <= IDLE;
                        bus.address_enable_n <= 1'b0;
                        bus.bus_wait_n       <= 1'b1;
                        bus.hold_acknowledge <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_hold_arbiter.sv
// Bench for bus_hold_arbiter: an unlimited-tenure instance and a MAX_TENURE=3 instance share the same stimulus.
module tb_bus_hold_arbiter;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [3:0] exp_q[$];
    logic [3:0] seen_grant = 4'b0;
    logic [3:0] sb_exp;

    bus_hold_arbiter_if #(.NUM_MASTERS(4)) bi ();
    bus_hold_arbiter_if #(.NUM_MASTERS(4)) ti ();

    assign ti.cpu_clock        = bi.cpu_clock;
    assign ti.processor_status = bi.processor_status;
    assign ti.processor_lock_n = bi.processor_lock_n;
    assign ti.rotate_priority  = bi.rotate_priority;
    assign ti.request          = bi.request;

    bus_hold_arbiter #(.NUM_MASTERS(4), .MAX_TENURE(0)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bi)
    );

    bus_hold_arbiter #(.NUM_MASTERS(4), .MAX_TENURE(3)) dut_t (
        .clock (clock),
        .reset (reset),
        .bus   (ti)
    );

    always #5 clock = ~clock;

    // Scoreboard: every new non-zero grant on the unlimited instance is matched against the queue.
    always @(negedge clock) begin
        if (bi.grant !== seen_grant && bi.grant !== 4'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_grant got=%b", bi.grant);
            end else begin
                sb_exp = exp_q.pop_front();
                if (bi.grant !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_grant got=%b expected=%b", bi.grant, sb_exp);
                end
            end
        end
        seen_grant = bi.grant;
    end

    task automatic cpu_edge(input logic v);
        @(negedge clock);
        bi.cpu_clock = v;
        @(posedge clock);
        #1;
    endtask

    task automatic pos_edge();
        if (bi.cpu_clock) cpu_edge(1'b0);
        cpu_edge(1'b1);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset        = 1'b1;
        bi.cpu_clock = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_grant(output bit got);
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            pos_edge();
            if (bi.grant !== 4'b0) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset               = 1'b1;
        bi.cpu_clock        = 1'b0;
        bi.processor_status = 3'b111;
        bi.processor_lock_n = 1'b1;
        bi.rotate_priority  = 1'b0;
        bi.request          = 4'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (bi.grant !== 4'b0) begin errors++; $display("FAIL reset_grant got=%b expected=0000", bi.grant); end
        checks++; if (bi.grant_index !== 2'd0) begin errors++; $display("FAIL reset_grant_index got=%0d expected=0", bi.grant_index); end
        checks++; if (bi.hold_acknowledge !== 1'b0) begin errors++; $display("FAIL reset_hold_ack got=%b expected=0", bi.hold_acknowledge); end
        checks++; if (bi.address_enable_n !== 1'b0) begin errors++; $display("FAIL reset_aen_n got=%b expected=0", bi.address_enable_n); end
        checks++; if (bi.bus_wait_n !== 1'b1) begin errors++; $display("FAIL reset_bus_wait_n got=%b expected=1", bi.bus_wait_n); end
        checks++; if (bi.tenure_expired !== 1'b0) begin errors++; $display("FAIL reset_tenure_expired got=%b expected=0", bi.tenure_expired); end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_single_hold();
        exp_q.push_back(4'b0001);
        bi.request = 4'b0001;
        pos_edge();
        checks++; if (bi.hold_acknowledge !== 1'b0) begin errors++; $display("FAIL single_sampled_hold_ack got=%b expected=0", bi.hold_acknowledge); end
        cpu_edge(1'b0);
        checks++; if (bi.hold_acknowledge !== 1'b1) begin errors++; $display("FAIL single_hold_ack got=%b expected=1", bi.hold_acknowledge); end
        checks++; if (bi.address_enable_n !== 1'b0) begin errors++; $display("FAIL single_hold_aen_n got=%b expected=0", bi.address_enable_n); end
        cpu_edge(1'b1);
        checks++; if (bi.address_enable_n !== 1'b1) begin errors++; $display("FAIL single_float_aen_n got=%b expected=1", bi.address_enable_n); end
        checks++; if (bi.grant !== 4'b0) begin errors++; $display("FAIL single_float_grant got=%b expected=0000", bi.grant); end
        pos_edge();
        checks++; if (bi.grant !== 4'b0001) begin errors++; $display("FAIL single_owned_grant got=%b expected=0001", bi.grant); end
        checks++; if (bi.bus_wait_n !== 1'b0) begin errors++; $display("FAIL single_owned_bus_wait_n got=%b expected=0", bi.bus_wait_n); end
        bi.request = 4'b0;
        pos_edge();
        checks++; if (bi.grant !== 4'b0) begin errors++; $display("FAIL single_release_grant got=%b expected=0000", bi.grant); end
        checks++; if (bi.address_enable_n !== 1'b1) begin errors++; $display("FAIL single_release_aen_n got=%b expected=1", bi.address_enable_n); end
        pos_edge();
        checks++; if (bi.address_enable_n !== 1'b0) begin errors++; $display("FAIL single_idle_aen_n got=%b expected=0", bi.address_enable_n); end
        checks++; if (bi.bus_wait_n !== 1'b1) begin errors++; $display("FAIL single_idle_bus_wait_n got=%b expected=1", bi.bus_wait_n); end
        checks++; if (bi.hold_acknowledge !== 1'b0) begin errors++; $display("FAIL single_idle_hold_ack got=%b expected=0", bi.hold_acknowledge); end
    endtask

    task automatic test_fixed_priority();
        bit got;
        exp_q.push_back(4'b0010);
        bi.request = 4'b0110;
        wait_grant(got);
        checks++; if (!got) begin errors++; $display("FAIL fixed_first_timeout got=%b expected=0010", bi.grant); end
        checks++; if (bi.grant_index !== 2'd1) begin errors++; $display("FAIL fixed_first_index got=%0d expected=1", bi.grant_index); end
        bi.request = 4'b0100;
        pos_edge();
        checks++; if (bi.grant !== 4'b0) begin errors++; $display("FAIL fixed_drop_grant got=%b expected=0000", bi.grant); end
        checks++; if (bi.address_enable_n !== 1'b1) begin errors++; $display("FAIL fixed_drop_aen_n got=%b expected=1", bi.address_enable_n); end
        pos_edge();
        checks++; if (bi.address_enable_n !== 1'b0) begin errors++; $display("FAIL fixed_return_aen_n got=%b expected=0", bi.address_enable_n); end
        exp_q.push_back(4'b0100);
        wait_grant(got);
        checks++; if (!got) begin errors++; $display("FAIL fixed_second_timeout got=%b expected=0100", bi.grant); end
        checks++; if (bi.grant_index !== 2'd2) begin errors++; $display("FAIL fixed_second_index got=%0d expected=2", bi.grant_index); end
        bi.request = 4'b0;
        pos_edge();
        pos_edge();
    endtask

    task automatic test_rotating();
        bit got;
        logic [3:0] want;
        apply_reset();
        bi.rotate_priority = 1'b1;
        want = 4'b0001;
        for (int n = 0; n < 5; n++) begin
            exp_q.push_back(want);
            want = {want[2:0], want[3]};
        end
        bi.request = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_grant(got);
            checks++; if (!got) begin errors++; $display("FAIL rotate_timeout round=%0d got=%b", n, bi.grant); end
            bi.request = 4'b1111 & ~bi.grant;
            pos_edge();
            bi.request = 4'b1111;
            pos_edge();
        end
        bi.request         = 4'b0;
        bi.rotate_priority = 1'b0;
        pos_edge();
    endtask

    task automatic test_tenure_limit();
        bit got;
        apply_reset();
        exp_q.push_back(4'b0001);
        bi.request = 4'b0001;
        wait_grant(got);
        checks++; if (!got) begin errors++; $display("FAIL tenure_grant_timeout got=%b expected=0001", bi.grant); end
        checks++; if (ti.grant !== 4'b0001) begin errors++; $display("FAIL tenure_initial_grant got=%b expected=0001", ti.grant); end
        pos_edge();
        pos_edge();
        checks++; if (ti.grant !== 4'b0001) begin errors++; $display("FAIL tenure_held_grant got=%b expected=0001", ti.grant); end
        checks++; if (ti.tenure_expired !== 1'b0) begin errors++; $display("FAIL tenure_early_pulse got=%b expected=0", ti.tenure_expired); end
        pos_edge();
        checks++; if (ti.grant !== 4'b0) begin errors++; $display("FAIL tenure_revoke_grant got=%b expected=0000", ti.grant); end
        checks++; if (ti.tenure_expired !== 1'b1) begin errors++; $display("FAIL tenure_pulse got=%b expected=1", ti.tenure_expired); end
        checks++; if (bi.grant !== 4'b0001) begin errors++; $display("FAIL tenure_unlimited_grant got=%b expected=0001", bi.grant); end
        @(posedge clock);
        #1;
        checks++; if (ti.tenure_expired !== 1'b0) begin errors++; $display("FAIL tenure_pulse_width got=%b expected=0", ti.tenure_expired); end
        pos_edge();
        checks++; if (ti.address_enable_n !== 1'b0) begin errors++; $display("FAIL tenure_cpu_aen_n got=%b expected=0", ti.address_enable_n); end
        checks++; if (ti.hold_acknowledge !== 1'b0) begin errors++; $display("FAIL tenure_cpu_hold_ack got=%b expected=0", ti.hold_acknowledge); end
        checks++; if (ti.tenure_expired !== 1'b0) begin errors++; $display("FAIL tenure_second_pulse got=%b expected=0", ti.tenure_expired); end
        repeat (4) pos_edge();
        checks++; if (ti.grant !== 4'b0001) begin errors++; $display("FAIL tenure_recompete got=%b expected=0001", ti.grant); end
        bi.request = 4'b0;
        pos_edge();
        pos_edge();
    endtask

    task automatic test_lock_and_status();
        bit got;
        bi.request          = 4'b0001;
        bi.processor_lock_n = 1'b0;
        for (int n = 0; n < 3; n++) begin
            pos_edge();
            checks++; if (bi.hold_acknowledge !== 1'b0 || bi.address_enable_n !== 1'b0) begin
                errors++; $display("FAIL lock_blocks got hold=%b aen_n=%b expected hold=0 aen_n=0", bi.hold_acknowledge, bi.address_enable_n);
            end
        end
        bi.processor_lock_n = 1'b1;
        bi.processor_status = 3'b100;
        for (int n = 0; n < 3; n++) begin
            pos_edge();
            checks++; if (bi.hold_acknowledge !== 1'b0 || bi.address_enable_n !== 1'b0) begin
                errors++; $display("FAIL status_blocks got hold=%b aen_n=%b expected hold=0 aen_n=0", bi.hold_acknowledge, bi.address_enable_n);
            end
        end
        exp_q.push_back(4'b0001);
        bi.processor_status = 3'b111;
        wait_grant(got);
        checks++; if (!got) begin errors++; $display("FAIL unlock_grant_timeout got=%b expected=0001", bi.grant); end
        checks++; if (bi.address_enable_n !== 1'b1) begin errors++; $display("FAIL unlock_aen_n got=%b expected=1", bi.address_enable_n); end
    endtask

    task automatic test_reset_mid_owned();
        checks++; if (bi.grant !== 4'b0001) begin errors++; $display("FAIL midreset_pre_grant got=%b expected=0001", bi.grant); end
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        checks++; if (bi.grant !== 4'b0) begin errors++; $display("FAIL midreset_grant got=%b expected=0000", bi.grant); end
        checks++; if (bi.address_enable_n !== 1'b0) begin errors++; $display("FAIL midreset_aen_n got=%b expected=0", bi.address_enable_n); end
        checks++; if (bi.bus_wait_n !== 1'b1) begin errors++; $display("FAIL midreset_bus_wait_n got=%b expected=1", bi.bus_wait_n); end
        checks++; if (bi.hold_acknowledge !== 1'b0) begin errors++; $display("FAIL midreset_hold_ack got=%b expected=0", bi.hold_acknowledge); end
        bi.request = 4'b0;
        #1;
        reset = 1'b0;
        pos_edge();
        checks++; if (bi.grant !== 4'b0 || bi.address_enable_n !== 1'b0) begin
            errors++; $display("FAIL midreset_after got grant=%b aen_n=%b expected grant=0000 aen_n=0", bi.grant, bi.address_enable_n);
        end
    endtask

    initial begin
        test_reset();
        test_single_hold();
        test_fixed_priority();
        test_rotating();
        test_tenure_limit();
        test_lock_and_status();
        test_reset_mid_owned();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_pending got=%0d expected=0 outstanding grants", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
